// File: rtl/crc_seq_ctrl_pkg.sv
// rtl/crc_seq_ctrl_pkg.sv - shared state and engine command encodings for the CRC sequencer
package crc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;

endpackage

// File: rtl/crc_seq_ctrl_reflect.sv
// rtl/crc_seq_ctrl_reflect.sv - width-aware bit reverse, XOR-out and mask of the engine register
module crc_reflect #(
    parameter int MAX_BITS = 64,
    parameter int WBITS    = 6
) (
    input  logic [MAX_BITS-1:0] value,
    input  logic [WBITS-1:0]    width,
    input  logic                rev_en,
    input  logic [MAX_BITS-1:0] xor_mask,
    output logic [MAX_BITS-1:0] result
);

    logic [MAX_BITS-1:0] rev;
    logic [MAX_BITS-1:0] mask;

    // Only bits [width:0] carry the CRC; reversal mirrors around that window.
    always_comb begin
        rev  = '0;
        mask = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i <= int'(width)) begin
                mask[i] = 1'b1;
                rev[i]  = value[WBITS'(int'(width) - i)];
            end
        end
        result = ((rev_en ? rev : value) ^ xor_mask) & mask;
    end

endmodule

// File: rtl/crc_seq_ctrl.sv
// rtl/crc_seq_ctrl.sv - byte-stream sequencer driving a bit-serial LFSR CRC engine
module crc_seq_ctrl
    import crc_seq_ctrl_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int WBITS    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WBITS-1:0]    cfg_width,
    input  logic                cfg_refin,
    input  logic                cfg_refout,
    input  logic [MAX_BITS-1:0] cfg_xorout,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                lfsr_load,
    output logic                lfsr_shift,
    output logic                lfsr_data,
    output logic [WBITS-1:0]    lfsr_width,
    input  logic [MAX_BITS-1:0] lfsr_value,
    output logic                crc_valid,
    input  logic                crc_ack,
    output logic [MAX_BITS-1:0] crc_out,
    output logic                busy
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          cmd;
    logic [2:0]          cnt_q;
    logic [7:0]          byte_q;
    logic                last_q;
    logic [WBITS-1:0]    width_q;
    logic                refin_q;
    logic                refout_q;
    logic [MAX_BITS-1:0] xorout_q;
    logic [MAX_BITS-1:0] crc_q;
    logic [MAX_BITS-1:0] crc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd       = CMD_HOLD;
        in_ready  = 1'b0;
        crc_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                cmd     = CMD_LOAD;
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                // A restart in the same cycle must not look like a consumed byte.
                in_ready = !start;
                if (in_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cmd = CMD_SHIFT;
                if (cnt_q == 3'd7) begin
                    state_d = last_q ? ST_FINAL : ST_ACCEPT;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b0;
                crc_valid = 1'b1;
                if (crc_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start) begin
            state_d = ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            width_q  <= '0;
            refin_q  <= 1'b0;
            refout_q <= 1'b0;
            xorout_q <= '0;
            crc_q    <= '0;
        end else begin
            if (start) begin
                width_q  <= cfg_width;
                refin_q  <= cfg_refin;
                refout_q <= cfg_refout;
                xorout_q <= cfg_xorout;
            end
            if (state_q == ST_ACCEPT && in_valid && !start) begin
                byte_q <= in_data;
                last_q <= in_last;
                cnt_q  <= '0;
            end
            if (state_q == ST_SHIFT) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (state_q == ST_FINAL && !start) begin
                crc_q <= crc_d;
            end
        end
    end

    crc_reflect #(
        .MAX_BITS (MAX_BITS),
        .WBITS    (WBITS)
    ) u_reflect (
        .value    (lfsr_value),
        .width    (width_q),
        .rev_en   (refout_q),
        .xor_mask (xorout_q),
        .result   (crc_d)
    );

    assign lfsr_load  = (cmd == CMD_LOAD);
    assign lfsr_shift = (cmd == CMD_SHIFT);
    assign lfsr_data  = (state_q == ST_SHIFT) &&
                        (refin_q ? byte_q[cnt_q] : byte_q[3'd7 - cnt_q]);
    assign lfsr_width = width_q;
    assign crc_out    = crc_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb/tb_crc_seq_ctrl.sv - self-checking bench for crc_seq_ctrl with a behavioural LFSR engine
module tb_crc_seq_ctrl;

    localparam int MB = 64;
    localparam int WB = 6;

    logic          clk = 1'b0;
    logic          rst, start, cfg_refin, cfg_refout;
    logic [WB-1:0] cfg_width, lfsr_width;
    logic [MB-1:0] cfg_xorout, lfsr_value, crc_out;
    logic          in_valid, in_ready, in_last;
    logic [7:0]    in_data;
    logic          lfsr_load, lfsr_shift, lfsr_data, crc_valid, crc_ack, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    crc_seq_ctrl #(.MAX_BITS(MB), .WBITS(WB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_refin(cfg_refin), .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .lfsr_load(lfsr_load), .lfsr_shift(lfsr_shift), .lfsr_data(lfsr_data),
        .lfsr_width(lfsr_width), .lfsr_value(lfsr_value),
        .crc_valid(crc_valid), .crc_ack(crc_ack), .crc_out(crc_out), .busy(busy)
    );

    function automatic logic [MB-1:0] wmask(input int w);
        logic [MB-1:0] m;
        m = '0;
        for (int i = 0; i < MB; i++) if (i <= w) m[i] = 1'b1;
        return m;
    endfunction

    // Behavioural MSB-first LFSR engine driven by the sequencer's commands.
    logic [MB-1:0] eng_taps, eng_init, eng_reg;
    assign lfsr_value = eng_reg;
    always @(posedge clk) begin
        if (rst) eng_reg <= '0;
        else if (lfsr_load) eng_reg <= eng_init & wmask(int'(lfsr_width));
        else if (lfsr_shift)
            eng_reg <= ((eng_reg << 1) & wmask(int'(lfsr_width))) ^
                       ((eng_reg[lfsr_width] ^ lfsr_data) ? (eng_taps & wmask(int'(lfsr_width))) : '0);
    end

    // Reference CRC from the textbook definition: optional byte reflection, polynomial division, output reflection.
    function automatic logic [MB-1:0] ref_crc(input int w, input logic [MB-1:0] taps, init, xo,
                                               input logic ri, ro, input logic [7:0] msg[$]);
        logic [MB-1:0] m, r, o;
        logic [7:0]    b, rb;
        logic          fb;
        m = wmask(w);
        r = init & m;
        foreach (msg[j]) begin
            b = msg[j];
            for (int i = 0; i < 8; i++) rb[i] = b[7-i];
            if (ri) b = rb;
            for (int k = 7; k >= 0; k--) begin
                fb = r[w] ^ b[k];
                r  = ((r << 1) & m) ^ (fb ? (taps & m) : '0);
            end
        end
        if (ro) begin
            o = '0;
            for (int i = 0; i <= w; i++) o[i] = r[w-i];
            r = o;
        end
        return (r ^ xo) & m;
    endfunction

    task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(lfsr_load && lfsr_shift)) else begin
                failures++;
                $error("FAIL load_shift_overlap observed=1 expected=0");
            end
            checks++;
            assert (busy || (!lfsr_load && !lfsr_shift)) else begin
                failures++;
                $error("FAIL cmd_when_idle observed=%0b%0b expected=00", lfsr_load, lfsr_shift);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_load"}, lfsr_load, 0);
        chk({tag, "_shift"}, lfsr_shift, 0);
        chk({tag, "_data"}, lfsr_data, 0);
        chk({tag, "_width"}, lfsr_width, 0);
        chk({tag, "_crc_valid"}, crc_valid, 0);
        chk({tag, "_crc_out"}, crc_out, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_crc(input string tag, input int w, input logic [MB-1:0] taps, init, xo,
                           input logic ri, ro, input logic [7:0] msg[$], input bit bp,
                           input bit do_start, output logic [MB-1:0] res);
        int         idx, guard, last_hs, n;
        logic       hs;
        logic [7:0] b;
        eng_taps = taps;
        eng_init = init;
        cfg_width = w[WB-1:0]; cfg_refin = ri; cfg_refout = ro; cfg_xorout = xo;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk({tag, "_load"}, lfsr_load, 1);
        end
        cfg_width  = WB'($urandom);
        cfg_refin  = 1'($urandom);
        cfg_refout = 1'($urandom);
        cfg_xorout = {$urandom, $urandom};
        idx = 0; guard = 0; last_hs = cyc;
        while (idx < msg.size() && guard < 2000) begin
            in_valid = bp ? 1'($urandom) : 1'b1;
            in_data  = msg[idx];
            in_last  = (idx == msg.size() - 1);
            hs = in_valid && in_ready;
            if (hs) last_hs = cyc;
            tick();
            guard++;
            if (hs) begin
                b = msg[idx];
                for (int k = 0; k < 8; k++) begin
                    in_valid = bp ? 1'($urandom) : 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    chk({tag, "_shift"}, lfsr_shift, 1);
                    chk({tag, "_bit"}, lfsr_data, ri ? b[k] : b[7-k]);
                    chk({tag, "_ready_in_shift"}, in_ready, 0);
                    tick();
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_accept_timeout"}, guard < 2000, 1);
        n = 0;
        while (!crc_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, cyc - last_hs, 10);
        chk({tag, "_done_busy"}, busy, 0);
        res = crc_out;
    endtask

    initial begin
        logic [7:0]    m[$];
        logic [7:0]    rm[$];
        logic [MB-1:0] res, taps, init, xo;
        int            w;
        logic          ri, ro;
        bit            bp;

        rst = 1'b1; start = 1'b0; crc_ack = 1'b0;
        cfg_width = '0; cfg_refin = 1'b0; cfg_refout = 1'b0; cfg_xorout = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        eng_taps = '0; eng_init = '0;
        for (int i = 0; i < 9; i++) m.push_back(8'h31 + 8'(i));
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        chk("idle_ignore_ready", in_ready, 0);
        chk("idle_ignore_busy", busy, 0);
        in_valid = 1'b0;

        run_crc("crc8", 7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, m, 1'b0, 1'b1, res);
        chk("crc8_value", res, 64'hF4);
        run_crc("crc16", 15, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0, m, 1'b0, 1'b1, res);
        chk("crc16_value", res, 64'h29B1);
        run_crc("crc32", 31, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, m, 1'b0, 1'b1, res);
        chk("crc32_value", res, 64'hCBF43926);
        run_crc("bp_crc8", 7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, m, 1'b1, 1'b1, res);
        chk("bp_crc8_value", res, 64'hF4);

        for (int t = 0; t < 6; t++) begin
            w    = $urandom_range(7, 63);
            taps = {$urandom, $urandom};
            init = {$urandom, $urandom};
            xo   = {$urandom, $urandom};
            ri   = 1'($urandom);
            ro   = 1'($urandom);
            bp   = 1'($urandom);
            rm.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) rm.push_back(8'($urandom));
            run_crc("rand", w, taps, init, xo, ri, ro, rm, bp, 1'b1, res);
            chk("rand_value", res, ref_crc(w, taps, init, xo, ri, ro, rm));
        end

        // Restart during byte 4 with a different configuration.
        eng_taps = 64'h07; eng_init = 64'h0;
        cfg_width = 6'd7; cfg_refin = 1'b0; cfg_refout = 1'b0; cfg_xorout = '0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int g;
            in_valid = 1'b1; in_data = m[i]; in_last = 1'b0;
            g = 0;
            while (!in_ready && g < 40) begin tick(); g++; end
            tick();
            in_valid = 1'b0;
        end
        repeat (3) tick();
        chk("restart_pre_shift", lfsr_shift, 1);
        cfg_width = 6'd15; cfg_xorout = '0; eng_taps = 64'h1021; eng_init = 64'hFFFF;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_load", lfsr_load, 1);
        chk("restart_busy", busy, 1);
        run_crc("restart", 15, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0, m, 1'b0, 1'b0, res);
        chk("restart_value", res, 64'h29B1);

        // Reset in the middle of shifting.
        eng_taps = 64'h04C11DB7; eng_init = 64'hFFFFFFFF;
        cfg_width = 6'd31; cfg_refin = 1'b1; cfg_refout = 1'b1; cfg_xorout = 64'hFFFFFFFF;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h31; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_mid_shift_pre", lfsr_shift, 1);
        rst = 1'b1; tick();
        chk_all_zero("rst_mid");
        rst = 1'b0; tick();

        // DONE hold, ack, then start+ack together.
        run_crc("hold", 7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, m, 1'b0, 1'b1, res);
        for (int i = 0; i < 20; i++) begin
            chk("hold_valid", crc_valid, 1);
            chk("hold_value", crc_out, 64'hF4);
            tick();
        end
        crc_ack = 1'b1; tick(); crc_ack = 1'b0;
        chk("ack_valid_drop", crc_valid, 0);
        chk("ack_idle_busy", busy, 0);
        tick();
        chk("ack_idle_no_load", lfsr_load, 0);
        run_crc("both", 7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, m, 1'b0, 1'b1, res);
        chk("both_value", res, 64'hF4);
        start = 1'b1; crc_ack = 1'b1; tick(); start = 1'b0; crc_ack = 1'b0;
        chk("start_ack_load", lfsr_load, 1);
        chk("start_ack_valid", crc_valid, 0);
        tick();
        chk("start_ack_accept", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
